// File: rtl/generator_pkg.sv
// Shared encodings for the tick-driven waveform generator.
package generator_pkg;

    // Waveform select codes; code 3 is reserved and behaves as saw.
    localparam logic [1:0] WAVE_SAW = 2'd0;
    localparam logic [1:0] WAVE_TRI = 2'd1;
    localparam logic [1:0] WAVE_SQR = 2'd2;

    // Triangle slope direction.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage : generator_pkg

// File: rtl/wave_shaper.sv
// Combinational next-state / sample mapping for one accepted tick.
// All registers live in tick_wavegen; this block only computes the step.
module wave_shaper
    import generator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] phase,
    input  dir_e             dir,
    output logic [WIDTH-1:0] phase_next,
    output dir_e             dir_next,
    output logic [WIDTH-1:0] sample_next,
    output logic             period_done_next
);

    localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);
    localparam logic [WIDTH:0]   STEP_W = {1'b0, STEP_N};
    localparam logic [WIDTH-1:0] MAX_N  = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   MAX_W  = {1'b0, MAX_N};

    // One extra bit so the saw carry and the triangle clamp are both visible.
    logic [WIDTH:0] sum;
    assign sum = {1'b0, phase} + STEP_W;

    // Saw/square advance modulo 2^WIDTH; triangle saturates at MAX and 0.
    always_comb begin
        phase_next       = sum[WIDTH-1:0];
        dir_next         = dir;
        sample_next      = sum[WIDTH-1:0];
        period_done_next = sum[WIDTH];
        if (sel == WAVE_TRI) begin
            period_done_next = 1'b0;
            if (dir == DIR_UP) begin
                if (sum >= MAX_W) begin
                    phase_next = MAX_N;
                    dir_next   = DIR_DOWN;
                end
            end else begin
                if ({1'b0, phase} <= STEP_W) begin
                    phase_next       = '0;
                    dir_next         = DIR_UP;
                    period_done_next = 1'b1;
                end else begin
                    phase_next = phase - STEP_N;
                end
            end
            sample_next = phase_next;
        end else if (sel == WAVE_SQR) begin
            sample_next = {WIDTH{sum[WIDTH-1]}};
        end
    end

endmodule : wave_shaper

// File: rtl/tick_wavegen.sv
// Tick-driven waveform generator: saw, triangle and square outputs that
// advance one step per accepted tick (tick & enable).
module tick_wavegen
    import generator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             enable,
    input  logic [1:0]       wave_sel,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic             period_done
);

    logic [WIDTH-1:0] phase_reg;
    dir_e             dir_reg;
    logic [1:0]       sel_reg;
    logic [WIDTH-1:0] sample_reg;
    logic             sample_valid_reg;
    logic             period_done_reg;

    logic [WIDTH-1:0] phase_next;
    dir_e             dir_next;
    logic [WIDTH-1:0] sample_next;
    logic             period_done_next;

    logic accepted;
    assign accepted = tick & enable;

    wave_shaper #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_shaper (
        .sel              (sel_reg),
        .phase            (phase_reg),
        .dir              (dir_reg),
        .phase_next       (phase_next),
        .dir_next         (dir_next),
        .sample_next      (sample_next),
        .period_done_next (period_done_next)
    );

    // State update: a select change restarts the waveform, otherwise step it.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg        <= '0;
            dir_reg          <= DIR_UP;
            sel_reg          <= WAVE_SAW;
            sample_reg       <= '0;
            sample_valid_reg <= 1'b0;
            period_done_reg  <= 1'b0;
        end else begin
            sample_valid_reg <= 1'b0;
            period_done_reg  <= 1'b0;
            if (accepted) begin
                sample_valid_reg <= 1'b1;
                if (wave_sel != sel_reg) begin
                    sel_reg    <= wave_sel;
                    phase_reg  <= '0;
                    dir_reg    <= DIR_UP;
                    sample_reg <= '0;
                end else begin
                    phase_reg       <= phase_next;
                    dir_reg         <= dir_next;
                    sample_reg      <= sample_next;
                    period_done_reg <= period_done_next;
                end
            end
        end
    end

    assign sample       = sample_reg;
    assign sample_valid = sample_valid_reg;
    assign period_done  = period_done_reg;

endmodule : tick_wavegen
